// File: rtl/fpadd_pkg.sv
// Shared types and constants for the two-requester FP32 adder.
package fpadd_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXT_W = 27;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_t;
endpackage

// File: rtl/fpadd_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input returns 28.
module fpadd_lzc (
  input  logic [27:0] din,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd28;
    // scanning upward leaves the count of the highest set bit
    for (int i = 0; i < 28; i++)
      if (din[i]) cnt = 5'(27 - i);
  end
endmodule

// File: rtl/fpadd_arb.sv
// Two-requester arbitrated multi-cycle FP32 adder (flush-to-zero).
// Define FPADD_RNE_EN for round-to-nearest-even; default build truncates.
module fpadd_arb import fpadd_pkg::*; #(
  parameter int FIX_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        busy
);
  state_t state, nxt;
  logic   last, gnt, hs, id_q;
  fp_t    opa, opb;

  logic             sl, ss, spec;
  logic [EXP_W-1:0] el, d;
  logic [MAN_W:0]   ml, ms;
  logic [31:0]      spec_val;
  logic [EXT_W-1:0] xl, xs;
  logic [EXT_W:0]   sum;

  // ---------------- FSM ----------------
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (hs) nxt = CMP;
      CMP:     nxt = ALIGN;
      ALIGN:   nxt = ADD;
      ADD:     nxt = NORM;
      NORM:    nxt = DONE;
      DONE:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = (&req_valid) ? ((FIX_PRIO != 0) ? 1'b0 : ~last) : req_valid[1];
    req_ready = (state == IDLE && rst_n && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    hs        = |(req_valid & req_ready);
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
  end

  // ---------------- CMP ----------------
  logic [EXP_W-1:0] ea, eb, es;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_big;
  fp_t  c_sp;
  always_comb begin
    ea    = opa.e;
    eb    = opb.e;
    fa    = (ea == '0) ? '0 : opa.m;
    fb    = (eb == '0) ? '0 : opb.m;
    a_nan = (&ea) && (opa.m != '0);
    b_nan = (&eb) && (opb.m != '0);
    a_inf = (&ea) && (opa.m == '0);
    b_inf = (&eb) && (opb.m == '0);
    a_big = {ea, fa} >= {eb, fb};
    es    = a_big ? eb : ea;
    c_sp  = a_inf ? opa : opb;
  end

  // ---------------- ALIGN ----------------
  logic [EXT_W-1:0] sx, xs_n;
  always_comb begin
    sx = {ms, 3'b000};
    if (d >= 8'd27) xs_n = {{(EXT_W-1){1'b0}}, |sx};
    else            xs_n = (sx >> d) | {{(EXT_W-1){1'b0}}, |(sx & ~({EXT_W{1'b1}} << d))};
  end

  // ---------------- NORM / round ----------------
  logic [4:0]        lz;
  logic [EXT_W-1:0]  nm;
  logic signed [9:0] ne;
  logic              rnd;
  logic [24:0]       mr;
  logic [MAN_W-1:0]  frac;
  logic [31:0]       res;

  fpadd_lzc u_lzc (.din(sum), .cnt(lz));

  always_comb begin
    if (sum[EXT_W]) begin
      nm = sum[EXT_W:1] | {{(EXT_W-1){1'b0}}, sum[0]};
      ne = $signed({2'b00, el}) + 10'sd1;
    end else begin
      // bit 27 is the carry slot, so the hidden bit belongs at 26
      nm = EXT_W'(sum << (lz - 5'd1));
      ne = $signed({2'b00, el}) - $signed({5'b00000, lz}) + 10'sd1;
    end
`ifdef FPADD_RNE_EN
    rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
`else
    rnd = 1'b0 & (|nm[2:0]);
`endif
    mr   = {1'b0, nm[26:3]} + {24'd0, rnd};
    frac = mr[22:0];
    if (mr[24]) begin
      ne   = ne + 10'sd1;
      frac = mr[23:1];
    end
    if (spec)                res = spec_val;
    else if (sum == '0)      res = 32'h0;
    else if (ne >= 10'sd255) res = {sl, 8'hFF, 23'd0};
    else if (ne < 10'sd1)    res = {sl, 31'd0};
    else                     res = {sl, ne[7:0], frac};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 1'b1;
      resp_data <= '0;
      resp_id   <= 1'b0;
    end else begin
      if (hs) begin
        last <= gnt;
        id_q <= gnt;
        opa  <= gnt ? req1_a : req0_a;
        opb  <= gnt ? req1_b : req0_b;
      end
      case (state)
        CMP: begin
          sl       <= a_big ? opa.s : opb.s;
          ss       <= a_big ? opb.s : opa.s;
          el       <= a_big ? ea : eb;
          ml       <= a_big ? {|ea, fa} : {|eb, fb};
          ms       <= a_big ? {|eb, fb} : {|ea, fa};
          d        <= (a_big ? ea : eb) - es;
          spec     <= a_nan | b_nan | a_inf | b_inf;
          spec_val <= (a_nan || b_nan || (a_inf && b_inf && opa.s != opb.s)) ? QNAN : c_sp;
        end
        ALIGN: begin
          xl <= {ml, 3'b000};
          xs <= xs_n;
        end
        ADD: sum <= (sl == ss) ? {1'b0, xl} + {1'b0, xs} : {1'b0, xl} - {1'b0, xs};
        NORM: begin
          resp_data <= res;
          resp_id   <= id_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_arb.sv
// Directed self-checking bench for fpadd_arb (round-robin and fixed-priority instances).
module tb_fpadd_arb;
  logic        clk = 1'b0, rst_n = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req_ready, req_ready_f;
  logic        resp_valid, resp_valid_f, resp_id, resp_id_f, busy, busy_f;
  logic [31:0] resp_data, resp_data_f;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fpadd_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy));

  fpadd_arb #(.FIX_PRIO(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_f),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid_f), .resp_ready(resp_ready), .resp_data(resp_data_f),
    .resp_id(resp_id_f), .busy(busy_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; the FSM is IDLE on entry.
  task automatic xact(input logic [1:0] v, input bit keep, input int stall,
                      output logic [31:0] d, output logic id, output logic fid, output int lat);
    int n = 0;
    req_valid = v;
    #1;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    if (!keep) req_valid = 2'b00;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    d = resp_data; id = resp_id; fid = resp_id_f;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data",  resp_data, d);
      chk("stall_id",    32'(resp_id), 32'(id));
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy",  32'(busy), 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic        id, fid;
  int          lat;

  typedef struct { logic [31:0] a, b, exp; string tag; } vec_t;
  vec_t vecs[8];

  initial begin
    // reset with both requesters asserting
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data",  resp_data, 32'h0);
    chk("rst_id",    32'(resp_id), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // basic add on requester 0
    req0_a = 32'h3F800000; req0_b = 32'h40000000;
    xact(2'b01, 1'b0, 0, d, id, fid, lat);
    chk("add_1p2_data", d, 32'h40400000);
    chk("add_1p2_id",   32'(id), 32'd0);
    chk("add_1p2_lat",  32'(lat), 32'd5);

    vecs[0] = '{32'h3F800000, 32'hBF800000, 32'h00000000, "cancel_zero"};
    vecs[1] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf"};
    vecs[2] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf"};
    vecs[3] = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, "nan_in"};
    vecs[4] = '{32'h3F800000, 32'hFF800000, 32'hFF800000, "neg_inf_pass"};
    vecs[5] = '{32'hC0000000, 32'h3F800000, 32'hBF800000, "m2_plus_1"};
    vecs[6] = '{32'h00000001, 32'h3F800000, 32'h3F800000, "ftz_denorm"};
    vecs[7] = '{32'h40000000, 32'h40000000, 32'h40800000, "carry_out"};
    foreach (vecs[i]) begin
      req1_a = vecs[i].a; req1_b = vecs[i].b;
      xact(2'b10, 1'b0, 0, d, id, fid, lat);
      chk(vecs[i].tag, d, vecs[i].exp);
      chk({vecs[i].tag, "_id"}, 32'(id), 32'd1);
    end

    // rounding boundary: exact tie against odd and even lsb
    req0_a = 32'h3F800001; req0_b = 32'h33800000;
    xact(2'b01, 1'b0, 0, d, id, fid, lat);
`ifdef FPADD_RNE_EN
    chk("round_tie_odd", d, 32'h3F800002);
`else
    chk("round_tie_odd", d, 32'h3F800001);
`endif
    req0_a = 32'h3F800000; req0_b = 32'h33800000;
    xact(2'b01, 1'b0, 0, d, id, fid, lat);
    chk("round_tie_even", d, 32'h3F800000);

    // back-pressure in DONE with a pending request
    req0_a = 32'h3F800000; req0_b = 32'h40000000;
    xact(2'b01, 1'b1, 3, d, id, fid, lat);
    req_valid = 2'b00;
    chk("stall_result", d, 32'h40400000);

    // reset while in ALIGN abandons the operation
    req_valid = 2'b01;
    #1;
    chk("align_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("align_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    req1_a = 32'h40000000; req1_b = 32'h40000000;
    xact(2'b10, 1'b0, 0, d, id, fid, lat);
    chk("post_abort_id",   32'(id), 32'd1);
    chk("post_abort_data", d, 32'h40800000);

    // both valid held from reset: alternate vs fixed priority
    req0_a = 32'h3F800000; req0_b = 32'h40000000;
    rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xact(2'b11, 1'b1, 0, d, id, fid, lat);
      chk("rr_id",    32'(id), 32'(k % 2));
      chk("rr_data",  d, (k % 2 == 0) ? 32'h40400000 : 32'h40800000);
      chk("fix_id",   32'(fid), 32'd0);
    end
    req_valid = 2'b00;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpadd_arb.md
FPADD_ARB -- requirements
Module: fpadd_arb

Interface
REQ-001 Parameter FIX_PRIO, default 0: 0 = round-robin arbitration; 1 = requester 0 always wins when both request.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester add request; bit i is requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit set; handshake is valid&ready in the same cycle.
REQ-006 req0_a, req0_b  input  32 each  requester-0 IEEE-754 single operands.
REQ-007 req1_a, req1_b  input  32 each  requester-1 IEEE-754 single operands.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_data  output  32  a+b, IEEE-754 single.
REQ-011 resp_id  output  1  requester index owning resp_data.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, CMP, ALIGN, ADD, NORM and DONE, advancing one state per cycle except IDLE (waits for a request) and DONE (waits for resp_ready).
REQ-014 req_ready SHALL be nonzero only in IDLE, asserted combinationally for the granted requester when any req_valid is high; on handshake, operands and id are captured and the FSM enters CMP.
REQ-015 Round-robin: when both requesters are valid, grant goes to the requester not granted last; the last-grant pointer updates only on handshake.
REQ-016 CMP: order operands by {exp,mant} into larger L and smaller S; on equal magnitude, operand a is L; shift distance d = expL - expS (8 bits).
REQ-017 ALIGN: form 27-bit extended mantissas {hidden,mant[22:0],G,R,S}; shift S right by d, OR-ing shifted-out bits into the sticky bit; for d >= 27, S becomes sticky-only.
REQ-018 ADD: equal signs add, unequal signs compute L-S, into a 28-bit sum; result sign = sign of L.
REQ-019 NORM: on carry-out, shift right 1 and increment the exponent (sticky preserved); otherwise shift left by leading-zero count and decrement the exponent; apply rounding per REQ-027.
REQ-020 A zero sum SHALL produce +0 (0x00000000).
REQ-021 Exponent >= 255 after normalize/round SHALL produce signed infinity; an exponent below 1 SHALL produce signed zero.
REQ-022 Inputs with exp==0 SHALL be treated as zero (flush-to-zero); any NaN input, or inf + opposite-sign inf, SHALL produce 0x7FC00000; otherwise any inf input yields that inf.
REQ-023 DONE: resp_valid=1; resp_data and resp_id SHALL be held stable until resp_valid&resp_ready, then the FSM returns to IDLE; latency is accept edge to resp_valid = 5 cycles; the next accept is no earlier than the cycle after the response handshake.

Reset
REQ-024 On rst_n low at a clock edge: state=IDLE, resp_valid=0, resp_data=0, resp_id=0, last-grant pointer=1 (requester 0 wins first); req_ready=0 during reset.
REQ-025 Reset mid-operation SHALL abandon the operation with no response emitted.

Configuration
REQ-026 Macro FPADD_RNE_EN controls rounding.
REQ-027 With FPADD_RNE_EN defined: round-to-nearest-even using G,R,S; a rounding carry renormalizes (exponent+1). Without it: truncate toward zero, ignoring G,R,S.

Structure
REQ-028 Package fpadd_pkg SHALL hold the state enum, EXP_W=8, MAN_W=23, EXT_W=27, and QNAN=32'h7FC00000.
REQ-029 A sub-module fpadd_lzc (28-bit leading-zero counter, combinational) SHALL be used by NORM.

Verification
REQ-030 req0: a=0x3F800000, b=0x40000000 -> resp_data=0x40400000, resp_id=0, resp_valid 5 cycles after accept.
REQ-031 Both req_valid held from reset -> grants req0, req1, req0, ... alternately; with FIX_PRIO=1 -> always req0.
REQ-032 0x3F800000 + 0xBF800000 -> 0x00000000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x7F800000 + 0xFF800000 -> 0x7FC00000.
REQ-033 resp_ready low for 3 cycles in DONE -> resp_valid, resp_data and resp_id stable, req_ready=0, busy=1.
REQ-034 Rounding: 0x3F800001 + 0x33800000 -> 0x3F800002 with FPADD_RNE_EN, 0x3F800001 without; 0x3F800000 + 0x33800000 -> 0x3F800000 in both builds.
REQ-035 rst_n low during ALIGN -> next cycle busy=0, resp_valid=0; a following req1 request is accepted with resp_id=1.
